// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage: the decode-facing
// fetch bundle, the fetch FSM states and the reset PC.
package fetch_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PCINIT_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic valid;
    u64   pc;
    u32   raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_adder.sv
// Plain W-bit wrapping adder, used for the sequential pc+4 computation.
module fetch_unit_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding bus request, one-entry hold buffer
// toward decode, and wrong-path squash on decode redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dataF_valid,
  output logic [63:0] dataF_pc,
  output logic [31:0] dataF_raw_instr
);

  fetch_state_t r_state, w_state_n;
  u64 r_pc, w_pc_n;
  u64 r_req_addr, w_req_addr_n;
  u64 r_buf_pc, w_buf_pc_n;
  u32 r_buf_instr, w_buf_instr_n;
  u64 w_pc_plus4;
  logic w_redir;
  fetch_data_t w_dataF;

  // Decode operands may be stale during a stall, so redirects only count when not stalled.
  assign w_redir = redirect_valid & ~stallF;

  fetch_unit_adder #(.W(64)) u_pc_inc (
    .a  (r_req_addr),
    .b  (64'd4),
    .sum(w_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= PCINIT;
      r_req_addr  <= PCINIT;
      r_buf_pc    <= '0;
      r_buf_instr <= '0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_req_addr  <= w_req_addr_n;
      r_buf_pc    <= w_buf_pc_n;
      r_buf_instr <= w_buf_instr_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_req_addr_n  = r_req_addr;
    w_buf_pc_n    = r_buf_pc;
    w_buf_instr_n = r_buf_instr;
    unique case (r_state)
      FETCH: begin
        if (iresp_data_ok) begin
          if (w_redir) begin
            w_pc_n       = redirect_pc;
            w_req_addr_n = redirect_pc;
          end else begin
            w_buf_pc_n    = r_req_addr;
            w_buf_instr_n = iresp_data;
            w_pc_n        = w_pc_plus4;
            w_state_n     = HOLD;
          end
        end else if (w_redir) begin
          // Bus request must stay stable, so only the architectural PC moves.
          w_pc_n    = redirect_pc;
          w_state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (w_redir) w_pc_n = redirect_pc;
        if (iresp_data_ok) begin
          w_req_addr_n = w_redir ? redirect_pc : r_pc;
          w_state_n    = FETCH;
        end
      end
      HOLD: begin
        if (!stallF) begin
          w_pc_n       = w_redir ? redirect_pc : r_pc;
          w_req_addr_n = w_redir ? redirect_pc : r_pc;
          w_state_n    = FETCH;
        end
      end
      default: w_state_n = FETCH;
    endcase
  end

  assign ireq_valid = ~reset & (r_state != HOLD);
  assign ireq_addr  = r_req_addr;

  assign w_dataF.valid     = ~reset & (r_state == HOLD) & ~w_redir;
  assign w_dataF.pc        = r_buf_pc;
  assign w_dataF.raw_instr = r_buf_instr;

  assign dataF_valid     = w_dataF.valid;
  assign dataF_pc        = w_dataF.pc;
  assign dataF_raw_instr = w_dataF.raw_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/redirect/memory-latency traffic against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stallF;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dataF_valid;
  logic [63:0] dataF_pc;
  logic [31:0] dataF_raw_instr;

  int n_chk = 0;
  int n_err = 0;

  // Model: what decode holds, what is on the bus, and where fetch goes next.
  logic        m_have;
  logic [63:0] m_hpc;
  logic [31:0] m_hinstr;
  logic [63:0] m_req;
  logic        m_wrong;
  logic [63:0] m_next;

  fetch_unit #(.PCINIT(64'h8000_0000)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .stallF(stallF), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dataF_valid(dataF_valid), .dataF_pc(dataF_pc), .dataF_raw_instr(dataF_raw_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_have  = 1'b0;
    m_hpc   = '0;
    m_hinstr = '0;
    m_req   = 64'h8000_0000;
    m_wrong = 1'b0;
    m_next  = 64'h8000_0000;
  endfunction

  // Apply inputs for this cycle and compare outputs against the model.
  task automatic drive(input logic s, input logic rv, input logic [63:0] rp,
                       input logic dok, input logic [31:0] d);
    stallF = s; redirect_valid = rv; redirect_pc = rp;
    iresp_data_ok = dok; iresp_data = d;
    #1;
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, ~m_have});
    if (!m_have) chk("ireq_addr", ireq_addr, m_req);
    chk("dataF_valid", {63'd0, dataF_valid}, {63'd0, m_have & ~(rv & ~s)});
    if (m_have) begin
      chk("dataF_pc", dataF_pc, m_hpc);
      chk("dataF_instr", {32'd0, dataF_raw_instr}, {32'd0, m_hinstr});
    end
  endtask

  // Advance the model by one cycle using the inputs currently applied, then clock.
  task automatic tick();
    logic acc;
    acc = redirect_valid & ~stallF;
    if (m_have) begin
      if (!stallF) begin
        m_have = 1'b0;
        if (acc) m_next = redirect_pc;
        m_req   = m_next;
        m_wrong = 1'b0;
      end
    end else begin
      if (acc) m_next = redirect_pc;
      if (iresp_data_ok) begin
        if (m_wrong || acc) begin
          m_req   = m_next;
          m_wrong = 1'b0;
        end else begin
          m_have   = 1'b1;
          m_hpc    = m_req;
          m_hinstr = iresp_data;
          m_next   = m_req + 64'd4;
        end
      end else if (acc) m_wrong = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stallF = 0; redirect_valid = 0; redirect_pc = '0; iresp_data_ok = 0; iresp_data = '0;
    #1;
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_dataF_valid", {63'd0, dataF_valid}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stallF = 0; redirect_valid = 0; redirect_pc = '0; iresp_data_ok = 0; iresp_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 1-cycle memory, first fetch from reset PC.
    drive(0, 0, '0, 1, 32'h0000_0013);
    chk("t1_addr", ireq_addr, 64'h8000_0000);
    tick();
    drive(1, 0, '0, 0, '0);
    chk("t1_dv", {63'd0, dataF_valid}, 64'd1);
    chk("t1_pc", dataF_pc, 64'h8000_0000);
    chk("t1_instr", {32'd0, dataF_raw_instr}, 64'h13);
    tick();
    // Stalled hold; a redirect during stall is ignored.
    drive(1, 1, 64'h0000_DEAD_0000, 0, '0);
    chk("t2_ignored_dv", {63'd0, dataF_valid}, 64'd1);
    chk("t2_no_req", {63'd0, ireq_valid}, 64'd0);
    tick();
    drive(1, 0, '0, 0, '0);
    chk("t2_stable_pc", dataF_pc, 64'h8000_0000);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("t2_xfer", {63'd0, dataF_valid}, 64'd1);
    tick();
    drive(0, 0, '0, 1, 32'h1111_2222);
    chk("t2_next_addr", ireq_addr, 64'h8000_0004);
    tick();
    // Redirect while holding squashes the presented instruction.
    drive(0, 1, 64'h8000_0100, 0, '0);
    chk("t3_squash", {63'd0, dataF_valid}, 64'd0);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("t3_addr", ireq_addr, 64'h8000_0100);
    tick();
    // Redirect while a request is in flight: drain, then fetch target.
    drive(0, 1, 64'h8000_0200, 0, '0);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("t4_stable", ireq_addr, 64'h8000_0100);
    tick();
    drive(0, 0, '0, 1, 32'hBAD0_BAD0);
    chk("t4_stable2", ireq_addr, 64'h8000_0100);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("t4_addr", ireq_addr, 64'h8000_0200);
    chk("t4_no_dv", {63'd0, dataF_valid}, 64'd0);
    tick();
    // Redirect and data_ok together: data dropped.
    drive(0, 1, 64'h8000_0300, 1, 32'hBAD1_BAD1);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("t5_addr", ireq_addr, 64'h8000_0300);
    chk("t5_drop", {63'd0, dataF_valid}, 64'd0);
    tick();
    drive(0, 0, '0, 1, 32'h3333_4444);
    tick();
    // Reset while holding, then while draining.
    do_reset();
    drive(0, 0, '0, 0, '0);
    chk("t6_addr", ireq_addr, 64'h8000_0000);
    chk("t6_req", {63'd0, ireq_valid}, 64'd1);
    tick();
    drive(0, 1, 64'h8000_0400, 0, '0);
    tick();
    do_reset();
    drive(0, 0, '0, 0, '0);
    chk("t6b_addr", ireq_addr, 64'h8000_0000);
    // PC wrap at top of address space.
    drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0);
    tick();
    drive(0, 0, '0, 1, 32'hBAD2_BAD2);
    tick();
    drive(0, 0, '0, 1, 32'h5555_6666);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("wrap_pc", dataF_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(0, 0, '0, 0, '0);
    chk("wrap_addr", ireq_addr, 64'h0);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic s, rv, dok;
      logic [63:0] rp;
      s   = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 15);
      rp  = {$urandom(), $urandom()} & ~64'd3;
      dok = !m_have && ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        drive(s, rv, rp, dok, $urandom());
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
